// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute control sequencer for a microcoded CPU.
//
// Latches an instruction into IR during FETCH. It then steps through up to four
// EXEC cycles, driving the decoder-supplied control word onto the datapath.
// An external halt request parks it in HALT.
//
// Ports:
//   clock      in   system clock, rising-edge active
//   reset      in   asynchronous active-high reset
//   instr_in   in   [31:0] instruction word from instruction memory
//   mem_ready  in   instr_in valid this cycle
//   halt_req   in   request to stop fetching (sampled only in FETCH/HALT)
//   cw_dec     in   [32:0] decoder control word (combinational from IR/state/status)
//   flags_in   in   [4:0] ALU status flags
//   IR         out  [31:0] instruction register
//   state      out  [1:0] execute-step index
//   status     out  [4:0] status register
//   cw         out  [32:0] control word to the datapath
//   fetching   out  high in FETCH
//   halted     out  high in HALT
//   seq_error  out  sticky step-counter overrun flag
module cpu_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic        mem_ready,
  input  logic        halt_req,
  input  logic [32:0] cw_dec,
  input  logic [4:0]  flags_in,
  output logic [31:0] IR,
  output logic [1:0]  state,
  output logic [4:0]  status,
  output logic [32:0] cw,
  output logic        fetching,
  output logic        halted,
  output logic        seq_error
);

  // Control word with every enable low, PC holding and all register selects at r31.
  localparam logic [32:0] NopCw = {1'b0,          // alu_en
                                   1'b0,          // alu_bs
                                   5'd0,          // alu_fs
                                   1'b0,          // rf_b_en
                                   5'd31,         // rf_sa
                                   5'd31,         // rf_sb
                                   5'd31,         // rf_da
                                   1'b0,          // rf_w
                                   1'b0,          // ram_en
                                   1'b0,          // ram_w
                                   1'b0,          // pc_en
                                   2'b00,         // pc_fs
                                   1'b0,          // pc_is
                                   1'b0,          // status_ld
                                   2'b00};        // next_state

  localparam logic [2:0] MaxSteps = 3'd4;

  typedef enum logic [1:0] {StFetch, StExec, StHalt} phase_e;

  phase_e      phase_q, phase_d;
  logic [31:0] ir_q, ir_d;
  logic [1:0]  state_q, state_d;
  logic [4:0]  status_q, status_d;
  logic [2:0]  step_q, step_d;       // EXEC cycles completed for the current instruction
  logic        err_q, err_d;

  logic [2:0]  step_inc;
  assign step_inc = step_q + 3'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q  <= StFetch;
      ir_q     <= 32'd0;
      state_q  <= 2'd0;
      status_q <= 5'd0;
      step_q   <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      ir_q     <= ir_d;
      state_q  <= state_d;
      status_q <= status_d;
      step_q   <= step_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    ir_d     = ir_q;
    state_d  = state_q;
    status_d = status_q;
    step_d   = step_q;
    err_d    = err_q;
    unique case (phase_q)
      StFetch: begin
        // Halt wins over an instruction that is ready in the same cycle.
        if (halt_req) begin
          phase_d = StHalt;
        end else if (mem_ready) begin
          ir_d    = instr_in;
          state_d = 2'd0;
          step_d  = 3'd0;
          phase_d = StExec;
        end
      end
      StExec: begin
        step_d = step_inc;
        if (cw_dec[2]) begin
          status_d = flags_in;
        end
        if (cw_dec[1:0] == 2'd0) begin
          state_d = 2'd0;
          step_d  = 3'd0;
          phase_d = StFetch;
        end else if (step_inc == MaxSteps) begin
          // Microcode asked for a fifth step: abort back to FETCH and flag it.
          state_d = 2'd0;
          step_d  = 3'd0;
          err_d   = 1'b1;
          phase_d = StFetch;
        end else begin
          state_d = cw_dec[1:0];
        end
      end
      StHalt: begin
        if (!halt_req) begin
          phase_d = StFetch;
        end
      end
      default: begin
        phase_d = StFetch;
      end
    endcase
  end

  always_comb begin
    cw       = NopCw;
    fetching = 1'b0;
    halted   = 1'b0;
    unique case (phase_q)
      StFetch: fetching = 1'b1;
      StExec:  cw       = cw_dec;
      StHalt:  halted   = 1'b1;
      default: fetching = 1'b1;
    endcase
  end

  assign IR        = ir_q;
  assign state     = state_q;
  assign status    = status_q;
  assign seq_error = err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus a random run,
// with post-edge expectations queued from a behavioural model.
module tb_cpu_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_in = 32'd0;
  logic        mem_ready = 1'b0;
  logic        halt_req = 1'b0;
  logic [32:0] cw_dec = 33'd0;
  logic [4:0]  flags_in = 5'd0;
  logic [31:0] IR;
  logic [1:0]  state;
  logic [4:0]  status;
  logic [32:0] cw;
  logic        fetching;
  logic        halted;
  logic        seq_error;

  cpu_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .instr_in  (instr_in),
    .mem_ready (mem_ready),
    .halt_req  (halt_req),
    .cw_dec    (cw_dec),
    .flags_in  (flags_in),
    .IR        (IR),
    .state     (state),
    .status    (status),
    .cw        (cw),
    .fetching  (fetching),
    .halted    (halted),
    .seq_error (seq_error)
  );

  always #5 clock = ~clock;

  localparam logic [32:0] Nop = 33'h0_01FF_FC00;

  typedef struct {
    logic [31:0] ir;
    logic [1:0]  st;
    logic [4:0]  stat;
    logic        err;
    logic        fetch;
    logic        halt;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 = FETCH, 1 = EXEC, 2 = HALT.
  int          m_phase;
  logic [31:0] m_ir;
  logic [1:0]  m_state;
  logic [4:0]  m_status;
  int          m_steps;
  logic        m_err;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_ir     = 32'd0;
    m_state  = 2'd0;
    m_status = 5'd0;
    m_steps  = 0;
    m_err    = 1'b0;
  endtask

  task automatic model_step(input logic [31:0] ins, input logic mr, input logic hr,
                            input logic [32:0] cwd, input logic [4:0] fl);
    case (m_phase)
      0: begin
        if (hr) m_phase = 2;
        else if (mr) begin
          m_ir = ins; m_state = 2'd0; m_steps = 0; m_phase = 1;
        end
      end
      1: begin
        m_steps++;
        if (cwd[2]) m_status = fl;
        if (cwd[1:0] == 2'd0) begin
          m_state = 2'd0; m_phase = 0; m_steps = 0;
        end else if (m_steps == 4) begin
          m_state = 2'd0; m_phase = 0; m_steps = 0; m_err = 1'b1;
        end else begin
          m_state = cwd[1:0];
        end
      end
      default: if (!hr) m_phase = 0;
    endcase
  endtask

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic run_cycle(input logic [31:0] ins, input logic mr, input logic hr,
                           input logic [32:0] cwd, input logic [4:0] fl);
    exp_t e;
    instr_in = ins; mem_ready = mr; halt_req = hr; cw_dec = cwd; flags_in = fl;
    #1;
    check_eq("cw", cw, (m_phase == 1) ? cwd : Nop);
    check_eq("fetching_pre", fetching, m_phase == 0);
    check_eq("halted_pre", halted, m_phase == 2);
    check_eq("state_pre", state, m_state);
    model_step(ins, mr, hr, cwd, fl);
    e.ir = m_ir; e.st = m_state; e.stat = m_status; e.err = m_err;
    e.fetch = (m_phase == 0); e.halt = (m_phase == 2);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check_eq("IR", IR, e.ir);
    check_eq("state", state, e.st);
    check_eq("status", status, e.stat);
    check_eq("seq_error", seq_error, e.err);
    check_eq("fetching", fetching, e.fetch);
    check_eq("halted", halted, e.halt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check_eq("rst_IR", IR, 32'd0);
    check_eq("rst_state", state, 2'd0);
    check_eq("rst_status", status, 5'd0);
    check_eq("rst_seq_error", seq_error, 1'b0);
    check_eq("rst_fetching", fetching, 1'b1);
    check_eq("rst_halted", halted, 1'b0);
    check_eq("rst_cw", cw, Nop);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Control word with a distinctive payload and chosen status_ld / next_state.
  function automatic logic [32:0] mk_cw(input logic ld, input logic [1:0] ns);
    logic [32:0] c;
    c = 33'h1_5A5A_5A58;
    c[2]   = ld;
    c[1:0] = ns;
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    #1;
    do_reset();

    // Fetch then single-step execute.
    run_cycle(32'hD2800020, 1'b1, 1'b0, mk_cw(1'b0, 2'd1), 5'd0);
    check_eq("fe_ir", IR, 32'hD2800020);
    check_eq("fe_exec", fetching, 1'b0);
    run_cycle(32'h0, 1'b1, 1'b0, mk_cw(1'b0, 2'd0), 5'd0);
    check_eq("fe_refetch", fetching, 1'b1);

    // Fetch stall for three cycles.
    for (int i = 0; i < 3; i++) begin
      run_cycle(32'h1111_2222, 1'b0, 1'b0, mk_cw(1'b0, 2'd1), 5'd0);
      check_eq("stall_ir", IR, 32'hD2800020);
    end
    run_cycle(32'h1111_2222, 1'b1, 1'b0, 33'd0, 5'd0);
    check_eq("stall_exec", fetching, 1'b0);
    run_cycle(32'h0, 1'b0, 1'b0, mk_cw(1'b0, 2'd0), 5'd0);

    // Multi-cycle with status load on step 2.
    run_cycle(32'hABCD_0001, 1'b1, 1'b0, 33'd0, 5'd0);
    run_cycle(32'h0, 1'b0, 1'b0, mk_cw(1'b0, 2'd1), 5'b11111);
    check_eq("mc_state1", state, 2'd1);
    run_cycle(32'h0, 1'b0, 1'b0, mk_cw(1'b1, 2'd2), 5'b01010);
    check_eq("mc_state2", state, 2'd2);
    run_cycle(32'h0, 1'b0, 1'b0, mk_cw(1'b0, 2'd0), 5'b10101);
    check_eq("mc_status", status, 5'b01010);
    check_eq("mc_fetch", fetching, 1'b1);

    // Halt request during EXEC is deferred until FETCH.
    run_cycle(32'h0BAD_F00D, 1'b1, 1'b0, 33'd0, 5'd0);
    run_cycle(32'h0, 1'b1, 1'b1, mk_cw(1'b0, 2'd1), 5'd0);
    check_eq("hlt_exec", fetching, 1'b0);
    run_cycle(32'h0, 1'b1, 1'b1, mk_cw(1'b0, 2'd0), 5'd0);
    run_cycle(32'h7777_7777, 1'b1, 1'b1, mk_cw(1'b0, 2'd1), 5'd0);
    check_eq("hlt_halted", halted, 1'b1);
    check_eq("hlt_ir", IR, 32'h0BAD_F00D);
    run_cycle(32'h7777_7777, 1'b1, 1'b1, mk_cw(1'b1, 2'd3), 5'd3);
    run_cycle(32'h7777_7777, 1'b1, 1'b0, mk_cw(1'b1, 2'd3), 5'd3);
    check_eq("hlt_resume", fetching, 1'b1);

    // Overrun: next_state stuck at 1.
    run_cycle(32'hCAFE_0004, 1'b1, 1'b0, 33'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      run_cycle(32'h0, 1'b0, 1'b0, mk_cw(1'b0, 2'd1), 5'd0);
      check_eq("ovr_in_exec", fetching, 1'b0);
    end
    check_eq("ovr_no_err_yet", seq_error, 1'b0);
    run_cycle(32'h0, 1'b0, 1'b0, mk_cw(1'b0, 2'd1), 5'd0);
    check_eq("ovr_fetch", fetching, 1'b1);
    check_eq("ovr_err", seq_error, 1'b1);
    run_cycle(32'hCAFE_0005, 1'b1, 1'b0, 33'd0, 5'd0);
    run_cycle(32'h0, 1'b0, 1'b0, mk_cw(1'b0, 2'd0), 5'd0);
    check_eq("ovr_sticky", seq_error, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 200; i++) begin
      logic [32:0] rc;
      rc = {$urandom_range(1, 0) == 1, $urandom()};
      run_cycle($urandom(), $urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0, rc,
                5'($urandom()));
    end

    // Asynchronous reset in the middle of an instruction.
    run_cycle(32'h1234_5678, 1'b1, 1'b0, 33'd0, 5'd0);
    if (m_phase != 1) run_cycle(32'h1234_5678, 1'b1, 1'b0, 33'd0, 5'd0);
    run_cycle(32'h0, 1'b0, 1'b0, mk_cw(1'b1, 2'd1), 5'b10101);
    check_eq("ar_status_set", status, 5'b10101);
    check_eq("ar_state_set", state, 2'd1);
    cw_dec = mk_cw(1'b1, 2'd2);
    flags_in = 5'b11111;
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_cw", cw, Nop);
    check_eq("ar_state", state, 2'd0);
    check_eq("ar_status", status, 5'd0);
    check_eq("ar_err", seq_error, 1'b0);
    check_eq("ar_fetching", fetching, 1'b1);
    model_reset();
    @(posedge clock);
    #1;
    check_eq("ar_hold_status", status, 5'd0);
    check_eq("ar_hold_ir", IR, 32'd0);
    reset = 1'b0;
    run_cycle(32'h5555_AAAA, 1'b1, 1'b0, 33'd0, 5'd0);
    check_eq("ar_first_fetch", IR, 32'h5555_AAAA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
